// File: rtl/jtag_mem_bridge.sv
// JTAG-to-memory bridge: a command chain sets address/mode/byte-enables, a data chain
// shifts write data in and prefetched read data out, with a latency-counted read engine.
module jtag_mem_bridge #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ADDR_STEP = 1,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic                TCK,
  input  logic                RESET,
  input  logic                CMD_SEL,
  input  logic                CMD_CAPTURE,
  input  logic                CMD_SHIFT,
  input  logic                CMD_UPDATE,
  input  logic                CMD_TDI,
  output logic                CMD_TDO,
  input  logic                DAT_SEL,
  input  logic                DAT_CAPTURE,
  input  logic                DAT_SHIFT,
  input  logic                DAT_UPDATE,
  input  logic                DAT_TDI,
  output logic                DAT_TDO,
  output logic [ADDR_W-1:0]   ADDR,
  output logic [DATA_W-1:0]   TO_MEM,
  output logic [DATA_W/8-1:0] BE,
  output logic                WREN,
  output logic                RDEN,
  input  logic [DATA_W-1:0]   FROM_MEM,
  output logic [5:0]          DBG
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CMD_W = ADDR_W + 2 + NB;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e             st_q, st_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [CMD_W-1:0]   cmd_sr_q, cmd_sr_d;
  logic [DATA_W-1:0]  dat_sr_q, dat_sr_d;
  logic [DATA_W-1:0]  rd_buf_q, rd_buf_d;
  logic [DATA_W-1:0]  to_mem_q, to_mem_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NB-1:0]      be_q, be_d;
  logic               wr_q, wr_d;
  logic               inc_q, inc_d;
  logic               busy_q, busy_d;
  logic               wren_q, wren_d;
  logic               rden_q, rden_d;
  // incr_pend: write with INC still owes the address bump; pf_pend: read bump owes a prefetch
  logic               incr_pend_q, incr_pend_d;
  logic               pf_pend_q, pf_pend_d;
  logic               cmd_cap, cmd_shift, cmd_upd;
  logic               dat_cap, dat_shift, dat_upd;
  logic               pf_go;
  logic               rd_pending;

  assign cmd_cap   = CMD_SEL & CMD_CAPTURE;
  assign cmd_shift = CMD_SEL & CMD_SHIFT;
  assign cmd_upd   = CMD_SEL & CMD_UPDATE;
  assign dat_cap   = DAT_SEL & DAT_CAPTURE;
  assign dat_shift = DAT_SEL & DAT_SHIFT;
  assign dat_upd   = DAT_SEL & DAT_UPDATE & ~cmd_upd;

  assign rd_pending = (st_q == StWait);

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    cmd_sr_d    = cmd_sr_q;
    dat_sr_d    = dat_sr_q;
    rd_buf_d    = rd_buf_q;
    to_mem_d    = to_mem_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wr_d        = wr_q;
    inc_d       = inc_q;
    busy_d      = busy_q;
    wren_d      = 1'b0;
    rden_d      = 1'b0;
    incr_pend_d = 1'b0;
    pf_pend_d   = 1'b0;
    pf_go       = 1'b0;

    if (cmd_cap) begin
      cmd_sr_d = {be_q, wr_q, inc_q, addr_q};
    end else if (cmd_shift) begin
      cmd_sr_d = {CMD_TDI, cmd_sr_q[CMD_W-1:1]};
    end

    if (dat_cap) begin
      dat_sr_d = rd_buf_q;
      if (rd_pending) busy_d = 1'b1;
    end else if (dat_shift) begin
      dat_sr_d = {DAT_TDI, dat_sr_q[DATA_W-1:1]};
    end

    if (incr_pend_q) begin
      addr_d = addr_q + ADDR_W'(ADDR_STEP);
      pf_go  = 1'b1;
    end
    if (pf_pend_q) pf_go = 1'b1;

    if (cmd_upd) begin
      addr_d = cmd_sr_q[ADDR_W-1:0];
      inc_d  = cmd_sr_q[ADDR_W];
      wr_d   = cmd_sr_q[ADDR_W+1];
      be_d   = cmd_sr_q[CMD_W-1:ADDR_W+2];
      busy_d = 1'b0;
      pf_go  = 1'b1;
    end else if (dat_upd) begin
      if (wr_q) begin
        to_mem_d    = dat_sr_q;
        wren_d      = 1'b1;
        incr_pend_d = inc_q;
      end else if (inc_q) begin
        addr_d    = addr_q + ADDR_W'(ADDR_STEP);
        pf_pend_d = 1'b1;
      end
    end

    unique case (st_q)
      StIdle: ;
      StWait: begin
        if (cnt_q == 3'd0) begin
          rd_buf_d = FROM_MEM;
          st_d     = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: st_d = StIdle;
    endcase

    // A new prefetch always restarts the engine; any in-flight result is dropped.
    if (pf_go) begin
      rden_d = 1'b1;
      st_d   = StWait;
      cnt_d  = 3'(READ_LAT);
    end
  end

  always_ff @(posedge TCK or posedge RESET) begin
    if (RESET) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      cmd_sr_q    <= '0;
      dat_sr_q    <= '0;
      rd_buf_q    <= '0;
      to_mem_q    <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wr_q        <= 1'b0;
      inc_q       <= 1'b0;
      busy_q      <= 1'b0;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      incr_pend_q <= 1'b0;
      pf_pend_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      dat_sr_q    <= dat_sr_d;
      rd_buf_q    <= rd_buf_d;
      to_mem_q    <= to_mem_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wr_q        <= wr_d;
      inc_q       <= inc_d;
      busy_q      <= busy_d;
      wren_q      <= wren_d;
      rden_q      <= rden_d;
      incr_pend_q <= incr_pend_d;
      pf_pend_q   <= pf_pend_d;
    end
  end

  assign CMD_TDO = cmd_sr_q[0];
  assign DAT_TDO = dat_sr_q[0];
  assign ADDR    = addr_q;
  assign TO_MEM  = to_mem_q;
  assign BE      = be_q;
  assign WREN    = wren_q;
  assign RDEN    = rden_q;
  assign DBG     = {busy_q, rd_pending, wr_q, inc_q, wren_q, rden_q};

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Directed bench: two bridges (READ_LAT=2 main, READ_LAT=4 for the reset-in-WAIT case)
// share one TAP stimulus; memory is modelled combinationally from each ADDR.
module tb_jtag_mem_bridge;

  localparam int CMD_W = 42;
  localparam logic [63:0] CONST_DATA = 64'hDEADBEEF_CAFEF00D;

  logic        TCK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_SEL = 0, CMD_CAPTURE = 0, CMD_SHIFT = 0, CMD_UPDATE = 0, CMD_TDI = 0;
  logic        DAT_SEL = 0, DAT_CAPTURE = 0, DAT_SHIFT = 0, DAT_UPDATE = 0, DAT_TDI = 0;
  logic        use_const = 1'b1;

  logic        cmd_tdo2, dat_tdo2, wren2, rden2;
  logic [31:0] addr2;
  logic [63:0] to_mem2, from_mem2;
  logic [7:0]  be2;
  logic [5:0]  dbg2;
  logic        cmd_tdo4, dat_tdo4, wren4, rden4;
  logic [31:0] addr4;
  logic [63:0] to_mem4, from_mem4;
  logic [7:0]  be4;
  logic [5:0]  dbg4;

  int passes = 0;
  int checks = 0;
  int fails  = 0;

  int          wr_cnt = 0;
  int          overlap = 0;
  logic [31:0] wr_addr [0:7];
  logic [63:0] wr_data [0:7];
  logic [7:0]  wr_be   [0:7];

  assign from_mem2 = use_const ? CONST_DATA : {32'b0, addr2} * 64'd3;
  assign from_mem4 = use_const ? CONST_DATA : {32'b0, addr4} * 64'd3;

  always #5 TCK = ~TCK;

  jtag_mem_bridge #(.DATA_W(64), .ADDR_W(32), .ADDR_STEP(1), .READ_LAT(2)) u_dut2 (
    .TCK(TCK), .RESET(RESET),
    .CMD_SEL(CMD_SEL), .CMD_CAPTURE(CMD_CAPTURE), .CMD_SHIFT(CMD_SHIFT),
    .CMD_UPDATE(CMD_UPDATE), .CMD_TDI(CMD_TDI), .CMD_TDO(cmd_tdo2),
    .DAT_SEL(DAT_SEL), .DAT_CAPTURE(DAT_CAPTURE), .DAT_SHIFT(DAT_SHIFT),
    .DAT_UPDATE(DAT_UPDATE), .DAT_TDI(DAT_TDI), .DAT_TDO(dat_tdo2),
    .ADDR(addr2), .TO_MEM(to_mem2), .BE(be2), .WREN(wren2), .RDEN(rden2),
    .FROM_MEM(from_mem2), .DBG(dbg2)
  );

  jtag_mem_bridge #(.DATA_W(64), .ADDR_W(32), .ADDR_STEP(1), .READ_LAT(4)) u_dut4 (
    .TCK(TCK), .RESET(RESET),
    .CMD_SEL(CMD_SEL), .CMD_CAPTURE(CMD_CAPTURE), .CMD_SHIFT(CMD_SHIFT),
    .CMD_UPDATE(CMD_UPDATE), .CMD_TDI(CMD_TDI), .CMD_TDO(cmd_tdo4),
    .DAT_SEL(DAT_SEL), .DAT_CAPTURE(DAT_CAPTURE), .DAT_SHIFT(DAT_SHIFT),
    .DAT_UPDATE(DAT_UPDATE), .DAT_TDI(DAT_TDI), .DAT_TDO(dat_tdo4),
    .ADDR(addr4), .TO_MEM(to_mem4), .BE(be4), .WREN(wren4), .RDEN(rden4),
    .FROM_MEM(from_mem4), .DBG(dbg4)
  );

  // Write-strobe log for the main bridge
  always @(negedge TCK) begin
    if (wren2 && rden2) overlap++;
    if (wren2) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = addr2;
        wr_data[wr_cnt] = to_mem2;
        wr_be[wr_cnt]   = be2;
      end
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge TCK);
  endtask

  // Entered at a negedge; returns at the negedge of cycle n+1 after the UPDATE edge n.
  task automatic cscan(input logic [CMD_W-1:0] v, output logic [CMD_W-1:0] r);
    CMD_SEL = 1'b1;
    CMD_CAPTURE = 1'b1;
    @(negedge TCK);
    CMD_CAPTURE = 1'b0;
    for (int i = 0; i < CMD_W; i++) begin
      CMD_SHIFT = 1'b1;
      CMD_TDI = v[i];
      r[i] = cmd_tdo2;
      @(negedge TCK);
    end
    CMD_SHIFT = 1'b0;
    CMD_UPDATE = 1'b1;
    @(negedge TCK);
    CMD_UPDATE = 1'b0;
  endtask

  task automatic dscan(input logic [63:0] w, output logic [63:0] r, output logic [63:0] r4);
    DAT_SEL = 1'b1;
    DAT_CAPTURE = 1'b1;
    @(negedge TCK);
    DAT_CAPTURE = 1'b0;
    for (int i = 0; i < 64; i++) begin
      DAT_SHIFT = 1'b1;
      DAT_TDI = w[i];
      r[i] = dat_tdo2;
      r4[i] = dat_tdo4;
      @(negedge TCK);
    end
    DAT_SHIFT = 1'b0;
    DAT_UPDATE = 1'b1;
    @(negedge TCK);
    DAT_UPDATE = 1'b0;
  endtask

  logic [CMD_W-1:0] cr;
  logic [63:0]      dr, dr4;

  initial begin
    // Reset values
    idle(2);
    check("rst_addr", 64'(addr2), 64'h0);
    check("rst_to_mem", to_mem2, 64'h0);
    check("rst_be", 64'(be2), 64'h0);
    check("rst_wren_rden", 64'({wren2, rden2}), 64'h0);
    check("rst_dbg", 64'(dbg2), 64'h0);
    check("rst_tdo", 64'({cmd_tdo2, dat_tdo2}), 64'h0);
    RESET = 1'b0;
    idle(2);

    // Command scan: ADDR=0x1000, INC=0, WR=0, BE=0xFF
    cscan({8'hFF, 1'b0, 1'b0, 32'h0000_1000}, cr);
    check("cmd1_addr", 64'(addr2), 64'h1000);
    check("cmd1_rden", 64'(rden2), 64'h1);
    check("cmd1_dbg", 64'(dbg2), 64'h11);
    idle(1);
    check("cmd1_rden_one", 64'(rden2), 64'h0);
    idle(8);
    dscan(64'h0, dr, dr4);
    check("read_const", dr, CONST_DATA);
    check("no_access_addr", 64'(addr2), 64'h1000);
    idle(8);

    // Burst write at 0x20 with INC, BE=0x0F
    cscan({8'h0F, 1'b1, 1'b1, 32'h0000_0020}, cr);
    check("cmd_capture_readback", 64'(cr), 64'({8'hFF, 1'b0, 1'b0, 32'h0000_1000}));
    idle(8);
    dscan(64'h11, dr, dr4);
    check("wr1_wren", 64'(wren2), 64'h1);
    check("wr1_addr_old", 64'(addr2), 64'h20);
    check("wr1_to_mem", to_mem2, 64'h11);
    idle(1);
    check("wr1_addr_inc", 64'(addr2), 64'h21);
    check("wr1_rden_wren", 64'({rden2, wren2}), 64'b10);
    idle(8);
    dscan(64'h22, dr, dr4);
    idle(8);
    dscan(64'h33, dr, dr4);
    idle(8);
    check("burst_wr_count", 64'(wr_cnt), 64'd3);
    check("burst_wr0", {wr_addr[0], wr_data[0][23:0], wr_be[0]}, {32'h20, 24'h11, 8'h0F});
    check("burst_wr1", {wr_addr[1], wr_data[1][23:0], wr_be[1]}, {32'h21, 24'h22, 8'h0F});
    check("burst_wr2", {wr_addr[2], wr_data[2][23:0], wr_be[2]}, {32'h22, 24'h33, 8'h0F});
    check("burst_end_addr", 64'(addr2), 64'h23);

    // Burst read from 5 with mem[a]=3a
    use_const = 1'b0;
    cscan({8'h00, 1'b0, 1'b1, 32'h0000_0005}, cr);
    idle(8);
    dscan(64'h0, dr, dr4);
    check("burst_rd0", dr, 64'd15);
    check("burst_rd0_addr", 64'(addr2), 64'd6);
    idle(8);
    dscan(64'h0, dr, dr4);
    check("burst_rd1", dr, 64'd18);
    idle(8);
    dscan(64'h0, dr, dr4);
    check("burst_rd2", dr, 64'd21);
    idle(8);
    check("burst_rd_no_wren", 64'(wr_cnt), 64'd3);

    // Address wrap-around
    cscan({8'h00, 1'b0, 1'b1, 32'hFFFF_FFFF}, cr);
    idle(8);
    dscan(64'h0, dr, dr4);
    check("wrap_rd", dr, 64'h2_FFFF_FFFD);
    check("wrap_addr", 64'(addr2), 64'h0);
    idle(1);
    check("wrap_prefetch", 64'({rden2, addr2}), {31'b0, 1'b1, 32'h0});
    idle(8);

    // Host-timing violation: capture two cycles after the command update
    cscan({8'h00, 1'b0, 1'b0, 32'h0000_0040}, cr);
    check("pre_violation_busy", 64'(dbg2[5]), 64'h0);
    idle(1);
    dscan(64'h0, dr, dr4);
    check("violation_busy", 64'(dbg2[5]), 64'h1);
    idle(8);
    check("busy_sticky", 64'(dbg2[5]), 64'h1);
    cscan({8'h00, 1'b0, 1'b0, 32'h0000_0040}, cr);
    check("busy_cleared", 64'(dbg2[5]), 64'h0);
    idle(8);

    // Reset while the READ_LAT=4 engine is waiting
    use_const = 1'b1;
    cscan({8'h3C, 1'b0, 1'b0, 32'h0000_0077}, cr);
    idle(2);
    check("lat4_in_wait", 64'(dbg4[4]), 64'h1);
    RESET = 1'b1;
    #1;
    check("rst4_addr_be", 64'({addr4, be4}), 64'h0);
    check("rst4_dbg_strobes", 64'({dbg4, wren4, rden4}), 64'h0);
    check("rst4_tdo", 64'({cmd_tdo4, dat_tdo4}), 64'h0);
    check("rst4_to_mem", to_mem4, 64'h0);
    check("rst2_to_mem", to_mem2, 64'h0);
    idle(2);
    RESET = 1'b0;
    idle(10);
    dscan(64'h0, dr, dr4);
    check("rst4_no_late_load", dr4, 64'h0);
    idle(2);
    check("no_wren_rden_overlap", 64'(overlap), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
